// File: rtl/vram_pkg.sv
// Shared constants and scroll-engine state encoding for the text RAM arbiter.
// Text layout: even byte = character code, odd byte = attribute.
package vram_pkg;

    localparam int COLS       = 80;
    localparam int ROWS       = 25;
    localparam int AW         = 12;
    localparam int ROW_BYTES  = 2 * COLS;
    localparam int COPY_LEN   = ROW_BYTES * (ROWS - 1);
    localparam int SCREEN_LEN = ROW_BYTES * ROWS;

    localparam logic [7:0] SPACE_CHAR = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RDW,
        WR,
        FILL,
        DONE
    } scroll_state_t;

endpackage

// File: rtl/vram_scroll_fsm.sv
// Scroll engine: copies text rows 1..ROWS-1 up by one row, then clears the
// bottom row with spaces in the latched attribute. One RAM access per request.
module vram_scroll_fsm
    import vram_pkg::*;
#(
    parameter int N_COLS = COLS,
    parameter int N_ROWS = ROWS,
    parameter int ADDR_W = AW
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        fill_attr,
    input  logic              grant,
    input  logic [7:0]        rdata,
    output logic              req,
    output logic              we,
    output logic [ADDR_W-1:0] address,
    output logic [7:0]        wdata,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(2 * N_COLS);
    localparam logic [ADDR_W-1:0] COPY_LAST = ADDR_W'(2 * N_COLS * (N_ROWS - 1) - 1);
    localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(2 * N_COLS * N_ROWS - 1);

    scroll_state_t     state, state_next;
    logic [ADDR_W-1:0] ptr, ptr_next;
    logic [7:0]        data_buf;
    logic [7:0]        attr_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ptr      <= '0;
            data_buf <= '0;
            attr_q   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            if (state == IDLE && start) attr_q <= fill_attr;
            // Read data arrives one cycle after RD was granted, whoever owns the bus now.
            if (state == RDW) data_buf <= rdata;
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        req        = 1'b0;
        we         = 1'b0;
        address    = '0;
        wdata      = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    ptr_next   = '0;
                    state_next = RD;
                end
            end
            RD: begin
                req     = 1'b1;
                address = ptr + ROW_STEP;
                if (grant) state_next = RDW;
            end
            RDW: state_next = WR;
            WR: begin
                req     = 1'b1;
                we      = 1'b1;
                address = ptr;
                wdata   = data_buf;
                if (grant) begin
                    ptr_next   = ptr + 1'b1;
                    state_next = (ptr == COPY_LAST) ? FILL : RD;
                end
            end
            FILL: begin
                req     = 1'b1;
                we      = 1'b1;
                address = ptr;
                wdata   = ptr[0] ? attr_q : SPACE_CHAR;
                if (grant) begin
                    ptr_next = ptr + 1'b1;
                    if (ptr == FILL_LAST) state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RD) || (state == RDW) || (state == WR) || (state == FILL);
    assign done = (state == DONE);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port text RAM arbiter: fixed priority GPU > CPU > scroll engine,
// with a three-cycle CPU transaction and a built-in scroll-up engine.
module vram_arbiter #(
    parameter int COLS = vram_pkg::COLS,
    parameter int ROWS = vram_pkg::ROWS,
    parameter int AW   = vram_pkg::AW
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          gpu_req,
    input  logic [AW-1:0] gpu_address,
    output logic [7:0]    gpu_data,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_address,
    input  logic [7:0]    cpu_wdata,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_ack,
    input  logic          scroll_start,
    input  logic [7:0]    fill_attr,
    output logic          scroll_busy,
    output logic          scroll_done,
    output logic [AW-1:0] ram_address,
    output logic          ram_we,
    output logic [7:0]    ram_wdata,
    input  logic [7:0]    ram_rdata
);

    logic          cpu_grant;
    logic          cpu_p1, cpu_p2, cpu_rd_p1;
    logic          scroll_req, scroll_we, scroll_grant;
    logic [AW-1:0] scroll_address;
    logic [7:0]    scroll_wdata;

    assign cpu_grant    = cpu_req && !gpu_req && !cpu_p1 && !cpu_p2;
    assign scroll_grant = scroll_req && !gpu_req && !cpu_grant;

    vram_scroll_fsm #(
        .N_COLS (COLS),
        .N_ROWS (ROWS),
        .ADDR_W (AW)
    ) u_scroll (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (scroll_start),
        .fill_attr (fill_attr),
        .grant     (scroll_grant),
        .rdata     (ram_rdata),
        .req       (scroll_req),
        .we        (scroll_we),
        .address   (scroll_address),
        .wdata     (scroll_wdata),
        .busy      (scroll_busy),
        .done      (scroll_done)
    );

    // Reset only gates the RAM-facing outputs so no write can slip out while reset is held.
    always_comb begin
        ram_address = '0;
        ram_we      = 1'b0;
        ram_wdata   = '0;
        if (reset_n) begin
            if (gpu_req) begin
                ram_address = gpu_address;
            end else if (cpu_grant) begin
                ram_address = cpu_address;
                ram_we      = cpu_we;
                ram_wdata   = cpu_wdata;
            end else if (scroll_grant) begin
                ram_address = scroll_address;
                ram_we      = scroll_we;
                ram_wdata   = scroll_wdata;
            end
        end
    end

    // Grant cycle N -> data cycle N+1 -> ack cycle N+2; no re-grant until N+3.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cpu_p1    <= 1'b0;
            cpu_p2    <= 1'b0;
            cpu_rd_p1 <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            cpu_p1    <= cpu_grant;
            cpu_p2    <= cpu_p1;
            cpu_rd_p1 <= cpu_grant && !cpu_we;
            if (cpu_rd_p1) cpu_rdata <= ram_rdata;
        end
    end

    assign cpu_ack  = cpu_p2;
    assign gpu_data = ram_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: behavioural RAM, directed CPU/GPU steps,
// full scrolls with random GPU load and CPU probes against a row/column memory model.
module tb_vram_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        gpu_req = 1'b0;
    logic [11:0] gpu_address = '0;
    logic [7:0]  gpu_data;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [11:0] cpu_address = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        scroll_start = 1'b0;
    logic [7:0]  fill_attr = '0;
    logic        scroll_busy;
    logic        scroll_done;
    logic [11:0] ram_address;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    always #5 clock = ~clock;

    vram_arbiter dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .gpu_req      (gpu_req),
        .gpu_address  (gpu_address),
        .gpu_data     (gpu_data),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_address  (cpu_address),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_ack      (cpu_ack),
        .scroll_start (scroll_start),
        .fill_attr    (fill_attr),
        .scroll_busy  (scroll_busy),
        .scroll_done  (scroll_done),
        .ram_address  (ram_address),
        .ram_we       (ram_we),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    // Synchronous-read RAM with a bench-side preload port.
    logic [7:0]  mem [4096];
    logic        bd_we = 1'b0;
    logic [11:0] bd_addr = '0;
    logic [7:0]  bd_data = '0;

    always @(posedge clock) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (ram_we) mem[ram_address] <= ram_wdata;
        ram_rdata <= mem[ram_address];
    end

    int         tests = 0;
    int         fails = 0;
    logic [7:0] hi_init [96];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Screen before scrolling: cell(r,c) = {char=r, attr=c}; bytes >= 4000 random.
    function automatic logic [7:0] preload_val(input int a);
        int row, col;
        if (a >= 4000) return hi_init[a - 4000];
        row = (a / 2) / 80;
        col = (a / 2) % 80;
        return (a % 2 == 1) ? 8'(col) : 8'(row);
    endfunction

    // Screen after one scroll: rows move up, bottom row is blank in attr.
    function automatic logic [7:0] scrolled_val(input int a, input logic [7:0] attr);
        int row, col;
        if (a >= 4000) return hi_init[a - 4000];
        row = (a / 2) / 80;
        col = (a / 2) % 80;
        if (row < 24) return (a % 2 == 1) ? 8'(col) : 8'(row + 1);
        return (a % 2 == 1) ? attr : 8'h20;
    endfunction

    task automatic preload();
        for (int a = 0; a < 4096; a++) begin
            bd_we   = 1'b1;
            bd_addr = 12'(a);
            bd_data = preload_val(a);
            tick();
        end
        bd_we = 1'b0;
    endtask

    task automatic verify_mem(input string tag, input logic [7:0] attr);
        int errs = 0;
        for (int a = 0; a < 4096; a++)
            if (mem[a] !== scrolled_val(a, attr)) errs++;
        check(tag, 32'(errs), 32'd0);
    endtask

    task automatic cpu_xfer(input string tag, input logic we, input logic [11:0] addr,
                            input logic [7:0] wdata, output int lat, output logic [7:0] rd);
        cpu_req     = 1'b1;
        cpu_we      = we;
        cpu_address = addr;
        cpu_wdata   = wdata;
        #1;
        check({tag, "_grant_we"}, 32'(ram_we), 32'(we));
        check({tag, "_grant_addr"}, 32'(ram_address), 32'(addr));
        lat = 0;
        while (lat < 10) begin
            tick();
            lat++;
            if (cpu_ack) break;
        end
        rd      = cpu_rdata;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        tick();
    endtask

    task automatic run_scroll(input string tag, input bit gpu_load, input bit repulse,
                              input int probe, output int cycles);
        int         k = 0;
        bit         done_seen = 0;
        bit         gpu_pend = 0;
        logic [7:0] gpu_exp = '0;
        int         gpu_reads = 0;
        int         gpu_bad = 0;
        int         probe_k = 0;
        fill_attr    = 8'h17;
        scroll_start = 1'b1;
        while (k < 30000 && !done_seen) begin
            tick();
            k++;
            scroll_start = 1'b0;
            fill_attr    = 8'h17;
            if (k == 1) check({tag, "_busy_after_start"}, 32'(scroll_busy), 32'd1);
            if (repulse && k == 100) begin
                scroll_start = 1'b1;
                fill_attr    = 8'h99;
            end
            if (gpu_pend) begin
                gpu_reads++;
                if (gpu_data !== gpu_exp) gpu_bad++;
            end
            gpu_pend = 0;
            gpu_req  = 1'b0;
            if (gpu_load && (k % 8) < 2) begin
                gpu_req     = 1'b1;
                gpu_address = 12'($urandom);
                gpu_exp     = mem[gpu_address];
                gpu_pend    = 1;
            end
            if (probe > 0 && k == probe) begin
                cpu_req     = 1'b1;
                cpu_we      = 1'b0;
                cpu_address = 12'hFA0;
                probe_k     = k;
            end else if (cpu_req && cpu_ack) begin
                check({tag, "_probe_latency"}, 32'(k - probe_k), 32'd2);
                check({tag, "_probe_data"}, 32'(cpu_rdata), 32'(hi_init[0]));
                cpu_req = 1'b0;
            end
            if (scroll_done) done_seen = 1;
        end
        gpu_req = 1'b0;
        cycles  = k;
        check({tag, "_done_seen"}, 32'(done_seen), 32'd1);
        if (probe > 0) check({tag, "_probe_acked"}, 32'(cpu_req), 32'd0);
        cpu_req = 1'b0;
        if (gpu_load) begin
            check({tag, "_gpu_read_errors"}, 32'(gpu_bad), 32'd0);
            check({tag, "_gpu_reads_seen"}, 32'(gpu_reads > 1000), 32'd1);
        end
        // A start coinciding with DONE must not launch another scroll.
        scroll_start = 1'b1;
        tick();
        scroll_start = 1'b0;
        check({tag, "_start_at_done_ignored"}, 32'(scroll_busy), 32'd0);
        tick();
        check({tag, "_idle_after_done"}, 32'(scroll_busy), 32'd0);
    endtask

    initial begin
        int         lat;
        int         cycles;
        logic [7:0] rd;
        logic [11:0] a2;
        logic [7:0]  d2;

        for (int i = 0; i < 96; i++) hi_init[i] = 8'($urandom);

        // Reset held with random inputs.
        reset_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            gpu_req      = 1'($urandom);
            gpu_address  = 12'($urandom);
            cpu_req      = 1'($urandom);
            cpu_we       = 1'($urandom);
            cpu_address  = 12'($urandom);
            cpu_wdata    = 8'($urandom);
            scroll_start = 1'($urandom);
            fill_attr    = 8'($urandom);
            tick();
        end
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_scroll_busy", 32'(scroll_busy), 32'd0);
        check("rst_scroll_done", 32'(scroll_done), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_address", 32'(ram_address), 32'd0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        gpu_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; scroll_start = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        // CPU write then read-back.
        a2 = 12'($urandom_range(12'h100, 12'hFFF));
        d2 = 8'($urandom);
        cpu_xfer("wr_010", 1'b1, 12'h010, 8'h41, lat, rd);
        check("wr_010_ack_latency", 32'(lat), 32'd2);
        cpu_xfer("wr_rand", 1'b1, a2, d2, lat, rd);
        check("wr_rand_ack_latency", 32'(lat), 32'd2);
        cpu_xfer("rd_010", 1'b0, 12'h010, 8'h00, lat, rd);
        check("rd_010_ack_latency", 32'(lat), 32'd2);
        check("rd_010_data", 32'(rd), 32'h41);
        cpu_xfer("rd_rand", 1'b0, a2, 8'h00, lat, rd);
        check("rd_rand_data", 32'(rd), 32'(d2));

        // GPU and CPU in the same cycle: GPU first, CPU one cycle later.
        gpu_req     = 1'b1;
        gpu_address = 12'h010;
        cpu_req     = 1'b1;
        cpu_we      = 1'b0;
        cpu_address = a2;
        #1;
        check("contend_gpu_addr", 32'(ram_address), 32'h010);
        check("contend_gpu_we", 32'(ram_we), 32'd0);
        tick();
        gpu_req = 1'b0;
        #1;
        check("contend_cpu_addr", 32'(ram_address), 32'(a2));
        check("contend_gpu_data", 32'(gpu_data), 32'h41);
        lat = 1;
        while (lat < 10) begin
            tick();
            lat++;
            if (cpu_ack) break;
        end
        check("contend_cpu_ack_latency", 32'(lat), 32'd3);
        check("contend_cpu_data", 32'(cpu_rdata), 32'(d2));
        cpu_req = 1'b0;
        tick();

        // Uncontended scroll with a start pulse while busy.
        preload();
        run_scroll("scroll_plain", 1'b0, 1'b1, 0, cycles);
        check("scroll_plain_cycles", 32'(cycles), 32'd11681);
        verify_mem("scroll_plain_mem", 8'h17);

        // Scroll under periodic GPU load.
        preload();
        run_scroll("scroll_gpu", 1'b1, 1'b0, 0, cycles);
        check("scroll_gpu_slower", 32'(cycles > 11681), 32'd1);
        verify_mem("scroll_gpu_mem", 8'h17);

        // CPU read of untouched memory while the scroll runs.
        preload();
        run_scroll("scroll_cpu", 1'b0, 1'b0, $urandom_range(200, 11000), cycles);
        verify_mem("scroll_cpu_mem", 8'h17);

        // Reset in the middle of a scroll abandons it immediately.
        scroll_start = 1'b1;
        tick();
        scroll_start = 1'b0;
        for (int i = 0; i < 50; i++) tick();
        check("midscroll_busy_before_reset", 32'(scroll_busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midscroll_rst_busy", 32'(scroll_busy), 32'd0);
        check("midscroll_rst_done", 32'(scroll_done), 32'd0);
        check("midscroll_rst_ram_we", 32'(ram_we), 32'd0);
        check("midscroll_rst_ram_address", 32'(ram_address), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("midscroll_stays_idle", 32'(scroll_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
